// File: rtl/proc_control.sv
// Purpose : control FSM for a simple multi-cycle processor (mv, mvi, add, sub) driving a shared register bus.
// Latency : Run sampled in T0; Done 1 cycle later for mv/mvi/undefined, 3 cycles later for add/sub.
// Backpressure: none; Run is a start request honoured only in T0 and ignored while an instruction is running.
//
// Ports:
//   Clock   - single clock, rising edge
//   Resetn  - asynchronous active-low reset; clears step counter and IR
//   Run     - start request, sampled only in T0
//   DIN     - instruction/immediate bus; instruction word in DIN[N-1:N-9]
//   IR      - latched instruction III XXX YYY
//   Rin     - per-register load enables, Rin[k] loads Rk
//   Rout    - per-register bus drive enables, Rout[k] drives Rk
//   Ain, Gin, Gout, DINout, AddSub, Done - datapath strobes and completion flag
module proc_control #(
    parameter int N = 16
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         Run,
    input  logic [N-1:0] DIN,
    output logic [8:0]   IR,
    output logic [0:7]   Rin,
    output logic [0:7]   Rout,
    output logic         Ain,
    output logic         Gin,
    output logic         Gout,
    output logic         DINout,
    output logic         AddSub,
    output logic         Done
);

    // Step counter encoding.
    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    // Opcodes (III field).
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    logic [1:0] tstep_q, tstep_d;
    logic [8:0] ir_q, ir_d;

    logic [2:0] opc;
    logic [2:0] xf;
    logic [2:0] yf;
    logic       is_addsub;
    logic [0:7] xsel;
    logic [0:7] ysel;

    // Only the top nine bits of DIN carry the instruction; the rest is
    // immediate data consumed by the datapath, not by this block.
    generate
        if (N > 9) begin : g_din_low
            logic unused_din_low;
            assign unused_din_low = ^DIN[N-10:0];
        end
    endgenerate

    // 3-bit register code to one-hot select; index k of the [0:7]
    // vector corresponds to register Rk.
    function automatic logic [0:7] dec3(input logic [2:0] code);
        logic [0:7] sel;
        sel       = '0;
        sel[code] = 1'b1;
        return sel;
    endfunction

    assign opc       = ir_q[8:6];
    assign xf        = ir_q[5:3];
    assign yf        = ir_q[2:0];
    assign is_addsub = (opc == OP_ADD) || (opc == OP_SUB);
    assign xsel      = dec3(xf);
    assign ysel      = dec3(yf);

    //------------------------------------------------------------------
    // Next-state logic: step counter and instruction register
    //------------------------------------------------------------------
    always_comb begin
        tstep_d = tstep_q;
        ir_d    = ir_q;
        case (tstep_q)
            T0: begin
                if (Run) begin
                    ir_d    = DIN[N-1:N-9];
                    tstep_d = T1;
                end
            end
            T1: begin
                // Only add/sub need the extra ALU steps.
                tstep_d = is_addsub ? T2 : T0;
            end
            T2: begin
                tstep_d = T3;
            end
            default: begin
                tstep_d = T0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            tstep_q <= T0;
            ir_q    <= 9'd0;
        end else begin
            tstep_q <= tstep_d;
            ir_q    <= ir_d;
        end
    end

    //------------------------------------------------------------------
    // Control decode: purely a function of the step and the latched IR,
    // so DIN/Run changes after T0 cannot disturb a running instruction.
    // Reset forces T0, which decodes to all-zero outputs.
    //------------------------------------------------------------------
    always_comb begin
        Rin    = '0;
        Rout   = '0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        DINout = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        case (tstep_q)
            T1: begin
                case (opc)
                    OP_MV: begin
                        Rout = ysel;
                        Rin  = xsel;
                        Done = 1'b1;
                    end
                    OP_MVI: begin
                        DINout = 1'b1;
                        Rin    = xsel;
                        Done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        Rout = xsel;
                        Ain  = 1'b1;
                    end
                    default: begin
                        // Undefined opcode: retire immediately, no transfer.
                        Done = 1'b1;
                    end
                endcase
            end
            T2: begin
                if (is_addsub) begin
                    Rout   = ysel;
                    Gin    = 1'b1;
                    AddSub = opc[0];
                end
            end
            T3: begin
                if (is_addsub) begin
                    Gout = 1'b1;
                    Rin  = xsel;
                    Done = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign IR = ir_q;

    //------------------------------------------------------------------
    // Protocol checks
    //------------------------------------------------------------------
    // Never more than one source on the shared bus.
    a_one_driver : assert property (@(posedge Clock) disable iff (!Resetn)
        $onehot0({Rout, Gout, DINout}));

    // Done is a single-cycle pulse; the step after it is always T0.
    a_done_pulse : assert property (@(posedge Clock) disable iff (!Resetn)
        Done |=> !Done);

    // Done only appears in an execution step, never while idle.
    a_done_step : assert property (@(posedge Clock) disable iff (!Resetn)
        Done |-> (tstep_q != T0));

endmodule

// File: tb/tb_proc_control.sv
module tb_proc_control;

    localparam int N = 16;

    logic         Clock;
    logic         Resetn;
    logic         Run;
    logic [N-1:0] DIN;
    logic [8:0]   IR;
    logic [0:7]   Rin;
    logic [0:7]   Rout;
    logic         Ain, Gin, Gout, DINout, AddSub, Done;

    int n_checks;
    int n_fail;
    logic prev_done;

    // Packed view of every control output: Rin[0..7], Rout[0..7],
    // then Ain Gin Gout DINout AddSub Done.
    logic [21:0] ctrl;
    assign ctrl = {Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done};

    proc_control #(.N(N)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Run    (Run),
        .DIN    (DIN),
        .IR     (IR),
        .Rin    (Rin),
        .Rout   (Rout),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .DINout (DINout),
        .AddSub (AddSub),
        .Done   (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Every cycle: bus single-driver rule and Done single-cycle rule.
    always @(negedge Clock) begin
        if (Resetn === 1'b1) begin
            n_checks++;
            if (!$onehot0({Rout, Gout, DINout})) begin
                n_fail++;
                $display("FAIL bus_one_driver t=%0t Rout=%b Gout=%b DINout=%b required at most one", $time, Rout, Gout, DINout);
            end
            n_checks++;
            if (Done === 1'b1 && prev_done === 1'b1) begin
                n_fail++;
                $display("FAIL done_one_cycle t=%0t Done high two cycles running, required single pulse", $time);
            end
            prev_done = Done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Resetn = 1'b1;
        Run    = 1'b0;
        DIN    = '0;
        #1 Resetn = 1'b0;
        #2;
        n_checks++;
        if (ctrl !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b required %b", ctrl, 22'd0);
        end
        n_checks++;
        if (IR !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_ir got %h required %h", IR, 9'd0);
        end
        Run = 1'b1;
        DIN = {9'b001_010_000, 7'h00};
        tick();
        n_checks++;
        if (ctrl !== 22'd0 || IR !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_hold ctrl=%b IR=%h required all zero", ctrl, IR);
        end
        Run    = 1'b0;
        Resetn = 1'b1;
        tick();
        n_checks++;
        if (ctrl !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_release_idle got %b required %b", ctrl, 22'd0);
        end
    endtask

    task automatic test_mvi();
        Run = 1'b1;
        DIN = {9'b001_010_000, 7'h2A};
        tick();
        Run = 1'b0;
        DIN = 16'hFFFF;
        #1;
        n_checks++;
        if (IR !== 9'h050) begin
            n_fail++;
            $display("FAIL mvi_ir got %h required %h", IR, 9'h050);
        end
        n_checks++;
        if (ctrl !== {8'b00100000, 8'b00000000, 6'b000101}) begin
            n_fail++;
            $display("FAIL mvi_t1 got %b required %b", ctrl, {8'b00100000, 8'b00000000, 6'b000101});
        end
        tick();
        n_checks++;
        if (ctrl !== 22'd0 || IR !== 9'h050) begin
            n_fail++;
            $display("FAIL mvi_t0 ctrl=%b IR=%h required ctrl 0 IR 050", ctrl, IR);
        end
    endtask

    task automatic test_sub();
        Run = 1'b1;
        DIN = {9'b011_001_110, 7'h55};
        tick();
        Run = 1'b0;
        DIN = 16'h1234;
        n_checks++;
        if (IR !== 9'b011_001_110) begin
            n_fail++;
            $display("FAIL sub_ir got %b required %b", IR, 9'b011_001_110);
        end
        n_checks++;
        if (ctrl !== {8'b00000000, 8'b01000000, 6'b100000}) begin
            n_fail++;
            $display("FAIL sub_t1 got %b required %b", ctrl, {8'b00000000, 8'b01000000, 6'b100000});
        end
        tick();
        n_checks++;
        if (ctrl !== {8'b00000000, 8'b00000010, 6'b010010}) begin
            n_fail++;
            $display("FAIL sub_t2 got %b required %b", ctrl, {8'b00000000, 8'b00000010, 6'b010010});
        end
        tick();
        n_checks++;
        if (ctrl !== {8'b01000000, 8'b00000000, 6'b001001}) begin
            n_fail++;
            $display("FAIL sub_t3 got %b required %b", ctrl, {8'b01000000, 8'b00000000, 6'b001001});
        end
        tick();
        n_checks++;
        if (ctrl !== 22'd0) begin
            n_fail++;
            $display("FAIL sub_t0 got %b required %b", ctrl, 22'd0);
        end
    endtask

    task automatic test_idle_ignore();
        Run = 1'b0;
        DIN = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (ctrl !== 22'd0 || IR !== 9'b011_001_110) begin
                n_fail++;
                $display("FAIL idle_cycle%0d ctrl=%b IR=%b required ctrl 0 IR 011001110", i, ctrl, IR);
            end
        end
        // add R4,R5 with Run pulsed while it runs
        Run = 1'b1;
        DIN = {9'b010_100_101, 7'h00};
        tick();
        Run = 1'b0;
        n_checks++;
        if (ctrl !== {8'b00000000, 8'b00001000, 6'b100000}) begin
            n_fail++;
            $display("FAIL ign_t1 got %b required %b", ctrl, {8'b00000000, 8'b00001000, 6'b100000});
        end
        tick();
        Run = 1'b1;
        DIN = {9'b001_111_000, 7'h00};
        #2 Run = 1'b0;
        #1 Run = 1'b1;
        n_checks++;
        if (ctrl !== {8'b00000000, 8'b00000100, 6'b010000}) begin
            n_fail++;
            $display("FAIL ign_t2 got %b required %b", ctrl, {8'b00000000, 8'b00000100, 6'b010000});
        end
        tick();
        n_checks++;
        if (ctrl !== {8'b00001000, 8'b00000000, 6'b001001}) begin
            n_fail++;
            $display("FAIL ign_t3 got %b required %b", ctrl, {8'b00001000, 8'b00000000, 6'b001001});
        end
        Run = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (ctrl !== 22'd0 || IR !== 9'b010_100_101) begin
                n_fail++;
                $display("FAIL ign_after%0d ctrl=%b IR=%b required ctrl 0 IR 010100101", i, ctrl, IR);
            end
        end
    endtask

    task automatic test_reset_abort();
        Run = 1'b1;
        DIN = {9'b010_001_010, 7'h00};
        tick();
        Run = 1'b0;
        tick();
        n_checks++;
        if (ctrl !== {8'b00000000, 8'b00100000, 6'b010000}) begin
            n_fail++;
            $display("FAIL abort_t2 got %b required %b", ctrl, {8'b00000000, 8'b00100000, 6'b010000});
        end
        #2 Resetn = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== 22'd0 || IR !== 9'd0) begin
            n_fail++;
            $display("FAIL abort_async ctrl=%b IR=%h required all zero before next edge", ctrl, IR);
        end
        tick();
        Resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (ctrl !== 22'd0) begin
                n_fail++;
                $display("FAIL abort_wait%0d got %b required %b", i, ctrl, 22'd0);
            end
        end
    endtask

    task automatic test_undef_and_same_reg();
        Run = 1'b1;
        DIN = {9'b101_011_011, 7'h7F};
        tick();
        Run = 1'b0;
        n_checks++;
        if (ctrl !== {8'b00000000, 8'b00000000, 6'b000001}) begin
            n_fail++;
            $display("FAIL undef_t1 got %b required %b", ctrl, {8'b00000000, 8'b00000000, 6'b000001});
        end
        tick();
        n_checks++;
        if (ctrl !== 22'd0) begin
            n_fail++;
            $display("FAIL undef_t0 got %b required %b", ctrl, 22'd0);
        end
        // mv R3,R3
        Run = 1'b1;
        DIN = {9'b000_011_011, 7'h00};
        tick();
        Run = 1'b0;
        n_checks++;
        if (ctrl !== {8'b00010000, 8'b00010000, 6'b000001}) begin
            n_fail++;
            $display("FAIL mv_same got %b required %b", ctrl, {8'b00010000, 8'b00010000, 6'b000001});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        // mv R0,R7 then add R1,R2 with Run held high: T1 | T0 T1 T2 T3
        Run = 1'b1;
        DIN = {9'b000_000_111, 7'h00};
        tick();
        n_checks++;
        if (ctrl !== {8'b10000000, 8'b00000001, 6'b000001}) begin
            n_fail++;
            $display("FAIL b2b_mv got %b required %b", ctrl, {8'b10000000, 8'b00000001, 6'b000001});
        end
        DIN = {9'b010_001_010, 7'h00};
        tick();
        n_checks++;
        if (ctrl !== 22'd0) begin
            n_fail++;
            $display("FAIL b2b_t0 got %b required %b", ctrl, 22'd0);
        end
        tick();
        n_checks++;
        if (ctrl !== {8'b00000000, 8'b01000000, 6'b100000}) begin
            n_fail++;
            $display("FAIL b2b_add_t1 got %b required %b", ctrl, {8'b00000000, 8'b01000000, 6'b100000});
        end
        tick();
        Run = 1'b0;
        n_checks++;
        if (ctrl !== {8'b00000000, 8'b00100000, 6'b010000}) begin
            n_fail++;
            $display("FAIL b2b_add_t2 got %b required %b", ctrl, {8'b00000000, 8'b00100000, 6'b010000});
        end
        tick();
        n_checks++;
        if (ctrl !== {8'b01000000, 8'b00000000, 6'b001001}) begin
            n_fail++;
            $display("FAIL b2b_add_t3 got %b required %b", ctrl, {8'b01000000, 8'b00000000, 6'b001001});
        end
        tick();
        n_checks++;
        if (ctrl !== 22'd0) begin
            n_fail++;
            $display("FAIL b2b_end got %b required %b", ctrl, 22'd0);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        prev_done = 1'b0;
        test_reset();
        test_mvi();
        test_sub();
        test_idle_ignore();
        test_reset_abort();
        test_undef_and_same_reg();
        test_back_to_back();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
